// File: rtl/simple_pkg.sv
// Types and constants shared by the simple counter/shift stimulus design and its
// receive-side checker.
package simple_pkg;

    typedef enum logic [1:0] {
        ADD_ZERO  = 2'd0,
        ADD_ONE   = 2'd1,
        ADD_TWO   = 2'd2,
        ADD_THREE = 2'd3
    } counter_add_e;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_e;

    // Bit positions inside mismatch_field.
    localparam int FLD_ADD   = 0;
    localparam int FLD_SHIFT = 1;
    localparam int FLD_LONG  = 2;
    localparam int FLD_ENUM  = 3;
    localparam int FLD_SYNC  = 4;
    localparam int FLD_W     = 5;

endpackage

// File: rtl/simple_checker_if.sv
// Output bus of the simple stimulus design: the source drives it (master), the
// checker consumes it (slave).
interface simple_checker_if #(
    parameter int CNT_W   = 2,
    parameter int SHIFT_W = 127,
    parameter int LONG_W  = 7000
);
    import simple_pkg::*;

    logic                sample_valid;
    logic [CNT_W-1:0]    counter_add_i;
    counter_add_e        counter_add_enum_i;
    logic [SHIFT_W-1:0]  counter_shift_i;
    logic [LONG_W-1:0]   super_long_i;

    modport master (
        output sample_valid, counter_add_i, counter_add_enum_i, counter_shift_i, super_long_i
    );

    modport slave (
        input sample_valid, counter_add_i, counter_add_enum_i, counter_shift_i, super_long_i
    );

endinterface

// File: rtl/simple_uniform_check.sv
// Single-cycle all-ones / all-zeros detector for a wide replicated-bit vector.
module simple_uniform_check #(
    parameter int W = 7000
) (
    input  logic [W-1:0] data_i,
    output logic         is_ones,
    output logic         is_zeros
);

    assign is_ones  = &data_i;
    assign is_zeros = ~|data_i;

endmodule

// File: rtl/simple_checker.sv
// Receive-side checker: locks onto a zero sample, then predicts each sample of the
// counter/shift bus from the previous one and keeps saturating error/sample counts.
module simple_checker
    import simple_pkg::*;
#(
    parameter int CNT_W   = 2,
    parameter int SHIFT_W = 127,
    parameter int LONG_W  = 7000,
    parameter int STAT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    simple_checker_if.slave    bus,
    output logic               locked,
    output logic               mismatch,
    output logic [FLD_W-1:0]   mismatch_field,
    output logic [STAT_W-1:0]  err_count,
    output logic [STAT_W-1:0]  sample_count
);

    state_e               state_q;
    logic                 locked_q;
    logic                 mismatch_q;
    logic [FLD_W-1:0]     field_q;
    logic [STAT_W-1:0]    err_q;
    logic [STAT_W-1:0]    smp_q;
    logic [CNT_W-1:0]     add_q;
    // The two top bits of the previous shift value never reach the next prediction.
    logic [SHIFT_W-3:0]   shift_q;

    logic                 is_ones;
    logic                 is_zeros;
    logic [FLD_W-1:0]     field_d;
    logic [CNT_W-1:0]     exp_add_d;
    logic [SHIFT_W-1:0]   exp_shift_d;
    logic                 sync_ok_d;

    simple_uniform_check #(.W(LONG_W)) u_uniform (
        .data_i   (bus.super_long_i),
        .is_ones  (is_ones),
        .is_zeros (is_zeros)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        field_d     = '0;
        exp_add_d   = add_q + CNT_W'(1);
        exp_shift_d = {shift_q, 2'b11};
        sync_ok_d   = (bus.counter_add_i == '0) && (bus.counter_shift_i == '0);

        if (bus.sample_valid) begin
            field_d[FLD_LONG] = bus.counter_add_i[CNT_W-1] ? !is_ones : !is_zeros;
            field_d[FLD_ENUM] = (bus.counter_add_enum_i != counter_add_e'(bus.counter_add_i[1:0]));
            if (state_q == IDLE) begin
                field_d[FLD_SYNC] = !sync_ok_d;
            end else begin
                field_d[FLD_ADD]   = (bus.counter_add_i != exp_add_d);
                field_d[FLD_SHIFT] = (bus.counter_shift_i != exp_shift_d);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            field_q    <= '0;
            err_q      <= '0;
            smp_q      <= '0;
            add_q      <= '0;
            shift_q    <= '0;
        end else begin
            mismatch_q <= |field_d;
            field_q    <= field_d;
            if ((|field_d) && (err_q != '1)) begin
                err_q <= err_q + STAT_W'(1);
            end

            if (bus.sample_valid) begin
                // Always reload from the observed sample so one bad value never cascades.
                add_q   <= bus.counter_add_i;
                shift_q <= bus.counter_shift_i[SHIFT_W-3:0];
                case (state_q)
                    IDLE: begin
                        if (sync_ok_d) begin
                            state_q  <= TRACK;
                            locked_q <= 1'b1;
                        end
                    end
                    TRACK: begin
                        if (smp_q != '1) begin
                            smp_q <= smp_q + STAT_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else begin
                state_q  <= IDLE;
                locked_q <= 1'b0;
            end
        end
    end

    assign locked         = locked_q;
    assign mismatch       = mismatch_q;
    assign mismatch_field = field_q;
    assign err_count      = err_q;
    assign sample_count   = smp_q;

endmodule

// File: tb/tb_simple_checker.sv
// Self-checking bench for simple_checker: directed scenarios plus a randomized run,
// compared against a sample-level reference model; two DUTs share the bus (STAT_W 16 and 4).
module tb_simple_checker;
    import simple_pkg::*;

    localparam int CNT_W   = 2;
    localparam int SHIFT_W = 127;
    localparam int LONG_W  = 7000;

    logic clk;
    logic rst;

    simple_checker_if #(.CNT_W(CNT_W), .SHIFT_W(SHIFT_W), .LONG_W(LONG_W)) bus ();

    logic        locked_a, mismatch_a, locked_b, mismatch_b;
    logic [4:0]  field_a, field_b;
    logic [15:0] err_a, smp_a;
    logic [3:0]  err_b, smp_b;

    simple_checker #(.CNT_W(CNT_W), .SHIFT_W(SHIFT_W), .LONG_W(LONG_W), .STAT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus),
        .locked(locked_a), .mismatch(mismatch_a), .mismatch_field(field_a),
        .err_count(err_a), .sample_count(smp_a)
    );

    simple_checker #(.CNT_W(CNT_W), .SHIFT_W(SHIFT_W), .LONG_W(LONG_W), .STAT_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus),
        .locked(locked_b), .mismatch(mismatch_b), .mismatch_field(field_b),
        .err_count(err_b), .sample_count(smp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model, one sample at a time.
    bit                  m_track;
    int                  m_add;
    logic [SHIFT_W-1:0]  m_shift;
    int                  m_err16, m_err4, m_smp16, m_smp4;
    bit                  m_mis;
    logic [4:0]          m_fld;

    // Source behaviour used to build legal samples.
    logic [1:0]          src_add;
    logic [SHIFT_W-1:0]  src_shift;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_sample(input bit r, input bit v, input logic [1:0] a, input logic [1:0] e,
                                input logic [SHIFT_W-1:0] s, input logic [LONG_W-1:0] l);
        logic [SHIFT_W-1:0] want_shift;
        bit counted;
        if (r) begin
            m_track = 0; m_add = 0; m_shift = '0;
            m_err16 = 0; m_err4 = 0; m_smp16 = 0; m_smp4 = 0;
            m_mis = 0; m_fld = '0;
            return;
        end
        m_fld = '0;
        counted = 0;
        if (v) begin
            if (l !== {LONG_W{a[1]}}) m_fld[2] = 1'b1;
            if (e !== a) m_fld[3] = 1'b1;
            if (!m_track) begin
                if (a == 0 && s == '0) m_track = 1;
                else m_fld[4] = 1'b1;
            end else begin
                counted = 1;
                if (int'(a) != (m_add + 1) % 4) m_fld[0] = 1'b1;
                want_shift = (m_shift << 2) | SHIFT_W'(3);
                if (s !== want_shift) m_fld[1] = 1'b1;
            end
            m_add = int'(a);
            m_shift = s;
        end else begin
            m_track = 0;
        end
        m_mis = (m_fld != 0);
        if (m_mis) begin
            if (m_err16 < 65535) m_err16++;
            if (m_err4 < 15) m_err4++;
        end
        if (counted) begin
            if (m_smp16 < 65535) m_smp16++;
            if (m_smp4 < 15) m_smp4++;
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [1:0] a, input logic [1:0] e,
                        input logic [SHIFT_W-1:0] s, input logic [LONG_W-1:0] l);
        @(negedge clk);
        rst                    = r;
        bus.sample_valid       = v;
        bus.counter_add_i      = a;
        bus.counter_add_enum_i = counter_add_e'(e);
        bus.counter_shift_i    = s;
        bus.super_long_i       = l;
        model_sample(r, v, a, e, s, l);
        @(posedge clk);
        #1;
        check("locked",     32'(locked_a),   32'(m_track));
        check("mismatch",   32'(mismatch_a), 32'(m_mis));
        check("field",      32'(field_a),    32'(m_fld));
        check("err_count",  32'(err_a),      32'(m_err16));
        check("smp_count",  32'(smp_a),      32'(m_smp16));
        check("locked4",    32'(locked_b),   32'(m_track));
        check("mismatch4",  32'(mismatch_b), 32'(m_mis));
        check("field4",     32'(field_b),    32'(m_fld));
        check("err_count4", 32'(err_b),      32'(m_err4));
        check("smp_count4", 32'(smp_b),      32'(m_smp4));
    endtask

    function automatic logic [LONG_W-1:0] long_for(input logic [1:0] a);
        return {LONG_W{a[1]}};
    endfunction

    task automatic src_restart();
        src_add   = 2'd0;
        src_shift = '0;
    endtask

    task automatic src_advance();
        src_add   = src_add + 2'd1;
        src_shift = {src_shift[SHIFT_W-3:0], 2'b11};
    endtask

    task automatic good();
        step(0, 1, src_add, src_add, src_shift, long_for(src_add));
        src_advance();
    endtask

    task automatic idle_cycle();
        step(0, 0, 2'd0, 2'd0, '0, '0);
    endtask

    initial begin
        logic [LONG_W-1:0]  l;
        logic [SHIFT_W-1:0] s;
        logic [1:0]         a, e;
        int                 r;

        rst = 1'b1;
        bus.sample_valid = 1'b0;
        bus.counter_add_i = '0;
        bus.counter_add_enum_i = ADD_ZERO;
        bus.counter_shift_i = '0;
        bus.super_long_i = '0;
        src_restart();

        // Reset state.
        step(1, 0, 2'd0, 2'd0, '0, '0);
        step(1, 1, 2'd3, 2'd1, '1, '0);

        // Clean counting stream, including the 3 -> 0 wrap and shift saturation.
        for (int i = 0; i < 70; i++) good();

        // Counter value 2 where 1 is expected, then clean from 2.
        idle_cycle();
        src_restart();
        good();
        src_add = 2'd2;
        for (int i = 0; i < 4; i++) good();

        // Top bit of super_long flipped, then the same plus an enum error.
        while (src_add != 2'd2) good();
        l = long_for(src_add);
        l[LONG_W-1] = ~l[LONG_W-1];
        step(0, 1, src_add, src_add, src_shift, l);
        src_advance();
        while (src_add != 2'd2) good();
        step(0, 1, src_add, 2'd0, src_shift, l);
        src_advance();
        good();

        // First valid sample nonzero: stays unlocked until a zero sample.
        idle_cycle();
        for (int i = 0; i < 3; i++) step(0, 1, 2'd1, 2'd1, '0, '0);
        src_restart();
        for (int i = 0; i < 3; i++) good();

        // Source drops valid mid-run, then relocks from zero.
        idle_cycle();
        idle_cycle();
        src_restart();
        for (int i = 0; i < 3; i++) good();

        // Twenty enum errors: the 4-bit error counter saturates.
        for (int i = 0; i < 20; i++) begin
            step(0, 1, src_add, ~src_add, src_shift, long_for(src_add));
            src_advance();
        end
        good();

        // Randomized stream with occasional drops and field corruptions.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                idle_cycle();
                if ($urandom_range(0, 1) == 1) src_restart();
            end else begin
                a = src_add;
                e = src_add;
                s = src_shift;
                l = long_for(src_add);
                if ($urandom_range(0, 99) < 8)  a = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 99) < 5)  e = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 99) < 5)  begin
                    int idx = int'($urandom_range(0, SHIFT_W - 1));
                    s[idx] = ~s[idx];
                end
                if ($urandom_range(0, 99) < 5)  begin
                    int idx = int'($urandom_range(0, LONG_W - 1));
                    l[idx] = ~l[idx];
                end
                step(0, 1, a, e, s, l);
                src_advance();
            end
        end

        // Reset in the middle of tracking clears everything.
        src_restart();
        for (int i = 0; i < 3; i++) good();
        step(0, 1, 2'd1, 2'd0, src_shift, '1);
        step(1, 1, src_add, src_add, src_shift, long_for(src_add));
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
